// File: rtl/exposure_readout_ctrl.sv
// Exposure/readout sequencer: erase in IDLE, expose for a latched time, then read rows
// with NRE/ADC strobes, DONE pulse. Define EXP_ABORT_EN to add the abort input.
module exposure_readout_ctrl #(
  parameter int ROWS       = 2,
  parameter int EXP_W      = 5,
  parameter int ADC_CYCLES = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         init,
  input  logic [EXP_W-1:0]                             exp_time,
`ifdef EXP_ABORT_EN
  input  logic                                         abort,
`endif
  output logic [ROWS-1:0]                              NRE,
  output logic                                         ADC,
  output logic                                         expose,
  output logic                                         erase,
  output logic                                         start,
  output logic                                         busy,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]   row_idx,
  output logic                                         done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int L  = ADC_CYCLES + 3;
  localparam int SW = $clog2(L);
  localparam logic [SW-1:0] SLOT_LAST = SW'(L - 1);
  localparam logic [SW-1:0] ADC_LAST  = SW'(ADC_CYCLES);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPOSURE,
    S_READOUT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [EXP_W-1:0]  exp_cnt_q, exp_cnt_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [RW-1:0]     row_q, row_d;

  logic [ROWS-1:0]   nre_d;
  logic              adc_d, expose_d, erase_d, start_d, busy_d, done_d;
  logic [RW-1:0]     row_idx_d;

  // Outputs are decoded from the next state/counters and registered alongside them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      e_q       <= '0;
      exp_cnt_q <= '0;
      slot_q    <= '0;
      row_q     <= '0;
      NRE       <= '1;
      ADC       <= 1'b0;
      expose    <= 1'b0;
      erase     <= 1'b1;
      start     <= 1'b0;
      busy      <= 1'b0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      exp_cnt_q <= exp_cnt_d;
      slot_q    <= slot_d;
      row_q     <= row_d;
      NRE       <= nre_d;
      ADC       <= adc_d;
      expose    <= expose_d;
      erase     <= erase_d;
      start     <= start_d;
      busy      <= busy_d;
      row_idx   <= row_idx_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    exp_cnt_d = '0;
    slot_d    = '0;
    row_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (init) begin
          e_d     = (exp_time == '0) ? EXP_W'(1) : exp_time;
          state_d = S_EXPOSURE;
        end
      end
      S_EXPOSURE: begin
        if (exp_cnt_q == e_q - EXP_W'(1)) begin
          state_d = S_READOUT;
        end else begin
          exp_cnt_d = exp_cnt_q + EXP_W'(1);
        end
      end
      S_READOUT: begin
        row_d  = row_q;
        slot_d = slot_q + SW'(1);
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef EXP_ABORT_EN
    if (abort && (state_q == S_EXPOSURE || state_q == S_READOUT)) begin
      state_d   = S_DONE;
      exp_cnt_d = '0;
      slot_d    = '0;
      row_d     = '0;
    end
`endif
  end

  always_comb begin
    nre_d     = '1;
    adc_d     = 1'b0;
    expose_d  = (state_d == S_EXPOSURE);
    erase_d   = (state_d == S_IDLE) || (state_d == S_DONE);
    start_d   = (state_q == S_IDLE) && (state_d == S_EXPOSURE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    row_idx_d = '0;
    if (state_d == S_READOUT) begin
      row_idx_d = row_d;
      adc_d     = (slot_d != '0) && (slot_d <= ADC_LAST);
      for (int unsigned k = 0; k < ROWS; k++) begin
        if (row_d == RW'(k) && slot_d != SLOT_LAST) begin
          nre_d[k] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exposure_readout_ctrl.sv
// Directed bench for exposure_readout_ctrl at ROWS=2, ADC_CYCLES=1, EXP_W=5.
// Each sample packs {NRE, ADC, expose, erase, start, busy, row_idx, done}.
module tb_exposure_readout_ctrl;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [4:0] exp_time;
  logic [1:0] NRE;
  logic       ADC, expose, erase, start, busy, done;
  logic [0:0] row_idx;
`ifdef EXP_ABORT_EN
  logic       abort;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [8:0] IDLE_V = 9'b11_0_0_1_0_0_0_0;
  localparam logic [8:0] EXP0_V = 9'b11_0_1_0_1_1_0_0;
  localparam logic [8:0] EXPN_V = 9'b11_0_1_0_0_1_0_0;
  localparam logic [8:0] DONE_V = 9'b11_0_0_1_0_1_0_1;
  logic [8:0] ro_v [8];

  exposure_readout_ctrl #(.ROWS(2), .EXP_W(5), .ADC_CYCLES(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .exp_time (exp_time),
`ifdef EXP_ABORT_EN
    .abort    (abort),
`endif
    .NRE      (NRE),
    .ADC      (ADC),
    .expose   (expose),
    .erase    (erase),
    .start    (start),
    .busy     (busy),
    .row_idx  (row_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] snap();
    return {NRE, ADC, expose, erase, start, busy, row_idx, done};
  endfunction

  task automatic chk(input string tag, input logic [8:0] exp_v);
    logic [8:0] obs;
    obs = snap();
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts from an IDLE sample point, ends at the IDLE sample after DONE.
  task automatic frame(input string tag, input logic [4:0] et, input int e,
                       input bit poke, input bit hold);
    init = 1'b1;
    exp_time = et;
    step();
    if (!hold) init = 1'b0;
    exp_time = 5'd3;
    for (int i = 0; i < e; i++) begin
      chk($sformatf("%s_exp%0d", tag, i), (i == 0) ? EXP0_V : EXPN_V);
      if (poke) init = (i == 1);
      step();
    end
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("%s_ro%0d", tag, c), ro_v[c]);
      if (poke) init = (c == 2);
      step();
    end
    if (poke) init = 1'b0;
    chk($sformatf("%s_done", tag), DONE_V);
    step();
    chk($sformatf("%s_idle", tag), IDLE_V);
  endtask

  initial begin
    ro_v[0] = 9'b10_0_0_0_0_1_0_0;
    ro_v[1] = 9'b10_1_0_0_0_1_0_0;
    ro_v[2] = 9'b10_0_0_0_0_1_0_0;
    ro_v[3] = 9'b11_0_0_0_0_1_0_0;
    ro_v[4] = 9'b01_0_0_0_0_1_1_0;
    ro_v[5] = 9'b01_1_0_0_0_1_1_0;
    ro_v[6] = 9'b01_0_0_0_0_1_1_0;
    ro_v[7] = 9'b11_0_0_0_0_1_1_0;
    reset = 1'b1;
    init = 1'b0;
    exp_time = 5'd0;
`ifdef EXP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_state", IDLE_V);
    reset = 1'b0;
    step();
    chk("idle_no_init", IDLE_V);

    frame("f5", 5'd5, 5, 1'b0, 1'b0);
    frame("f0", 5'd0, 1, 1'b0, 1'b0);
    frame("f31", 5'd31, 31, 1'b0, 1'b0);
    frame("poke", 5'd4, 4, 1'b1, 1'b0);
    step();
    chk("poke_no_restart", IDLE_V);

    frame("bb1", 5'd2, 2, 1'b0, 1'b1);
    frame("bb2", 5'd2, 2, 1'b0, 1'b0);
    step();
    chk("bb_stop", IDLE_V);

    // Reset lands while ADC is high in the first readout slot.
    init = 1'b1;
    exp_time = 5'd1;
    step();
    init = 1'b0;
    chk("rst_exp0", EXP0_V);
    step();
    chk("rst_ro0", ro_v[0]);
    step();
    chk("rst_ro1", ro_v[1]);
    reset = 1'b1;
    step();
    chk("rst_mid_ro", IDLE_V);
    init = 1'b1;
    step();
    chk("rst_over_init", IDLE_V);
    reset = 1'b0;
    init = 1'b0;
    step();
    chk("rst_release", IDLE_V);

`ifdef EXP_ABORT_EN
    init = 1'b1;
    exp_time = 5'd10;
    step();
    init = 1'b0;
    chk("ab_exp0", EXP0_V);
    step();
    chk("ab_exp1", EXPN_V);
    step();
    chk("ab_exp2", EXPN_V);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_done", DONE_V);
    step();
    chk("ab_idle", IDLE_V);
    step();
    chk("ab_idle2", IDLE_V);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
